// File: rtl/rca_seq_ctrl.sv
// Multi-precision add/subtract sequencer. A WIDTH-bit operand pair is pushed
// through a single 4-bit ripple-carry slice, one nibble per cycle, LSB first,
// with the inter-nibble carry held in a register. Results (sum, carry-out,
// signed overflow) are published with a start/busy/done handshake.

// 4-bit ripple-carry slice. Besides the carry out of bit 3 it exposes the
// carry into bit 3, which the controller needs for signed overflow when this
// slice is working on the most significant nibble.
module rca4_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       c3,
    output logic       co
);

    logic [4:0] c;

    // Full-adder chain, bit 0 to bit 3.
    always_comb begin
        // NOTE: combinational blocks use blocking '=' so each stage sees the carry
        // just computed by the stage below it; every output gets a default first
        // so no path through the block can infer a latch.
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < 4; i++) begin
            s[i]     = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        c3 = c[3];
        co = c[4];
    end

endmodule

// Sequencer around the slice. WIDTH must be a multiple of 4 and at least 4.
module rca_seq_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    // Derived nibble count; fixed by WIDTH, deliberately not a parameter.
    localparam int NIB = WIDTH / 4;
    // Counter width, kept at least one bit so WIDTH=4 still has a real counter.
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;       // nibble index k during RUN
    logic             carry_q, carry_d;   // carry between nibbles
    logic [WIDTH-1:0] a_q, a_d;           // operand A, shifted right one nibble per RUN cycle
    logic [WIDTH-1:0] b_q, b_d;           // operand B' (already inverted for subtract), shifted likewise
    logic [WIDTH-1:0] r_q, r_d;           // result nibbles enter at the top and shift down
    logic [WIDTH-1:0] s_q, s_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [3:0]       nib_sum;
    logic             nib_c3;
    logic             nib_co;
    logic             last_nib;

    // The current nibble always sits in the low four bits of the operand shifters.
    rca4_slice u_slice (
        .a  (a_q[3:0]),
        .b  (b_q[3:0]),
        .ci (carry_q),
        .s  (nib_sum),
        .c3 (nib_c3),
        .co (nib_co)
    );

    assign last_nib = (cnt_q == CW'(NIB - 1));

    // Next-state, datapath update and output-register load.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        s_d     = s_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start) begin
                    // Subtract is a + ~b + ~cin: inverting cin turns a borrow-in
                    // into the missing +1 of the two's complement.
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? ~cin : cin;
                    cnt_d   = '0;
                    r_d     = '0;
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                a_d                 = a_q >> 4;
                b_d                 = b_q >> 4;
                r_d                 = r_q >> 4;
                r_d[WIDTH-1 -: 4]   = nib_sum;
                carry_d             = nib_co;
                if (last_nib) begin
                    // The slice is on the MSB nibble: its carry-in to bit 3 is the
                    // carry into bit WIDTH-1.
                    cnt_d   = '0;
                    s_d     = r_d;
                    cout_d  = nib_co;
                    ovf_d   = nib_c3 ^ nib_co;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking '<=' so all registers update
        // together from values sampled before the edge; every register, datapath
        // included, is cleared so an aborted operation leaves no residue.
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);
    assign s    = s_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Scoreboard bench for rca_seq_ctrl: one WIDTH=16 instance and one WIDTH=4
// instance. Expected results come from plain integer arithmetic on the
// operands; a monitor compares them against done pulses and the hold values.
module tb_rca_seq_ctrl;

    typedef struct {
        logic [15:0] s;
        logic        cout;
        logic        ovf;
        int          acc;       // cycle index of the accepting edge
        int          done_cyc;  // cycle index at which done must be visible
    } exp_t;

    logic        clk;
    logic        rst;
    logic        start_i [2];
    logic        sub_i   [2];
    logic        cin_i   [2];
    logic [15:0] a_i     [2];
    logic [15:0] b_i     [2];
    logic        busy_o  [2];
    logic        done_o  [2];
    logic [15:0] s_o     [2];
    logic        cout_o  [2];
    logic        ovf_o   [2];
    logic [15:0] s16;
    logic [3:0]  s4;

    int          cyc;
    int          n_vec;
    int          n_err;
    bit          mon_en;
    int          free_at [2];
    exp_t        sb_q    [2][$];
    logic [15:0] held_s  [2];
    logic        held_c  [2];
    logic        held_v  [2];

    rca_seq_ctrl #(.WIDTH(16)) dut16 (
        .clk   (clk),
        .rst   (rst),
        .start (start_i[0]),
        .sub   (sub_i[0]),
        .a     (a_i[0]),
        .b     (b_i[0]),
        .cin   (cin_i[0]),
        .busy  (busy_o[0]),
        .done  (done_o[0]),
        .s     (s16),
        .cout  (cout_o[0]),
        .ovf   (ovf_o[0])
    );

    rca_seq_ctrl #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .rst   (rst),
        .start (start_i[1]),
        .sub   (sub_i[1]),
        .a     (a_i[1][3:0]),
        .b     (b_i[1][3:0]),
        .cin   (cin_i[1]),
        .busy  (busy_o[1]),
        .done  (done_o[1]),
        .s     (s4),
        .cout  (cout_o[1]),
        .ovf   (ovf_o[1])
    );

    assign s_o[0] = s16;
    assign s_o[1] = {12'h000, s4};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int nib_of(input int id);
        return (id == 0) ? 4 : 1;
    endfunction

    function automatic int width_of(input int id);
        return (id == 0) ? 16 : 4;
    endfunction

    // Reference: unsigned and signed arithmetic on the operand values.
    function automatic exp_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                   input logic sub, input logic cin);
        exp_t   e;
        longint mask, half, ua, ub, sa, sb, u, ss, ci;
        mask = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        ua   = longint'(a) & mask;
        ub   = longint'(b) & mask;
        ci   = cin ? 1 : 0;
        sa   = (ua >= half) ? ua - (mask + 1) : ua;
        sb   = (ub >= half) ? ub - (mask + 1) : ub;
        if (!sub) begin
            u      = ua + ub + ci;
            e.cout = (u > mask);
            ss     = sa + sb + ci;
        end else begin
            u      = ua - ub - ci;
            e.cout = (ua >= ub + ci);
            ss     = sa - sb - ci;
        end
        e.s        = 16'(u & mask);
        e.ovf      = (ss >= half) || (ss < -half);
        e.acc      = 0;
        e.done_cyc = 0;
        return e;
    endfunction

    task automatic check(input string name, input int id, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d cycle %0d: got %h, expected %h", name, id, cyc, act, exp);
        end
    endtask

    // One monitor step for one instance, run shortly after each rising edge.
    task automatic mon_step(input int id);
        exp_t e;
        logic exp_busy;
        exp_busy = (sb_q[id].size() != 0) && (cyc >= sb_q[id][0].acc) &&
                   (cyc < sb_q[id][0].done_cyc);
        check("busy", id, 32'(busy_o[id]), 32'(exp_busy));
        if (done_o[id] === 1'b1) begin
            if (sb_q[id].size() == 0) begin
                check("unexpected_done", id, 32'(done_o[id]), 32'd0);
            end else begin
                e = sb_q[id].pop_front();
                check("done_cycle", id, cyc, e.done_cyc);
                check("sum", id, 32'(s_o[id]), 32'(e.s));
                check("cout", id, 32'(cout_o[id]), 32'(e.cout));
                check("ovf", id, 32'(ovf_o[id]), 32'(e.ovf));
                held_s[id] = e.s;
                held_c[id] = e.cout;
                held_v[id] = e.ovf;
            end
        end else begin
            if (sb_q[id].size() != 0 && cyc >= sb_q[id][0].done_cyc) begin
                e = sb_q[id].pop_front();
                check("missing_done", id, 32'(done_o[id]), 32'd1);
                held_s[id] = e.s;
                held_c[id] = e.cout;
                held_v[id] = e.ovf;
            end else begin
                check("hold_s", id, 32'(s_o[id]), 32'(held_s[id]));
                check("hold_cout", id, 32'(cout_o[id]), 32'(held_c[id]));
                check("hold_ovf", id, 32'(ovf_o[id]), 32'(held_v[id]));
            end
        end
    endtask

    initial begin
        wait (mon_en);
        forever begin
            @(posedge clk);
            #1;
            mon_step(0);
            mon_step(1);
        end
    end

    // Reset both instances; any in-flight operation is dropped from the scoreboard.
    task automatic do_reset(input int cycles);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            start_i[i] = 1'b0;
            sb_q[i].delete();
            held_s[i] = '0;
            held_c[i] = 1'b0;
            held_v[i] = 1'b0;
        end
        repeat (cycles) @(negedge clk);
        rst = 1'b0;
        free_at[0] = cyc;
        free_at[1] = cyc;
    endtask

    // Issue one operation when the instance can accept it; afterwards scramble
    // the inputs and optionally pulse start again while the operation is running.
    task automatic issue(input int id, input logic [15:0] a, input logic [15:0] b,
                         input logic sub, input logic cin, input int gap, input bit poke);
        exp_t e;
        repeat (gap) @(negedge clk);
        while (cyc < free_at[id]) @(negedge clk);
        a_i[id]     = a;
        b_i[id]     = b;
        sub_i[id]   = sub;
        cin_i[id]   = cin;
        start_i[id] = 1'b1;
        e           = model(width_of(id), a, b, sub, cin);
        e.acc       = cyc + 1;
        e.done_cyc  = cyc + 1 + nib_of(id);
        sb_q[id].push_back(e);
        free_at[id] = e.done_cyc;
        @(negedge clk);
        start_i[id] = 1'b0;
        a_i[id]     = 16'($urandom);
        b_i[id]     = 16'($urandom);
        sub_i[id]   = 1'($urandom);
        cin_i[id]   = 1'($urandom);
        if (poke && cyc < free_at[id]) begin
            start_i[id] = 1'b1;
            @(negedge clk);
            start_i[id] = 1'b0;
            a_i[id]     = 16'($urandom);
            b_i[id]     = 16'($urandom);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && (sb_q[0].size() != 0 || sb_q[1].size() != 0); i++)
            @(negedge clk);
        check("drain_q", 0, sb_q[0].size(), 0);
        check("drain_q", 1, sb_q[1].size(), 0);
    endtask

    task automatic random_ops(input int id, input int count);
        for (int i = 0; i < count; i++)
            issue(id, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
                  int'($urandom_range(0, 3)), 1'($urandom));
    endtask

    initial begin
        cyc    = 0;
        n_vec  = 0;
        n_err  = 0;
        mon_en = 1'b0;
        rst    = 1'b1;
        for (int i = 0; i < 2; i++) begin
            start_i[i] = 1'b0;
            sub_i[i]   = 1'b0;
            cin_i[i]   = 1'b0;
            a_i[i]     = '0;
            b_i[i]     = '0;
        end
        @(negedge clk);
        do_reset(2);
        mon_en = 1'b1;
        repeat (2) @(negedge clk);

        // Directed cases; gap 0 makes consecutive ones back-to-back from DONE.
        issue(0, 16'h1234, 16'h0FCD, 1'b0, 1'b0, 0, 1'b1);
        issue(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0);
        issue(0, 16'hFFFF, 16'h0001, 1'b0, 1'b1, 0, 1'b1);
        issue(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 2, 1'b0);
        issue(0, 16'h8000, 16'hFFFF, 1'b0, 1'b0, 0, 1'b1);
        issue(0, 16'h0005, 16'h0007, 1'b1, 1'b0, 0, 1'b0);
        issue(0, 16'h0009, 16'h0003, 1'b1, 1'b1, 0, 1'b1);
        drain();

        // WIDTH=4 corners, then random traffic on both widths.
        issue(1, 16'h000F, 16'h0001, 1'b0, 1'b0, 0, 1'b1);
        issue(1, 16'h0007, 16'h0001, 1'b0, 1'b0, 0, 1'b0);
        issue(1, 16'h0008, 16'h0001, 1'b1, 1'b0, 0, 1'b1);
        random_ops(1, 40);
        drain();
        random_ops(0, 60);
        drain();

        // Abort in the second RUN cycle; no done may follow.
        issue(0, 16'h1234, 16'h0FCD, 1'b0, 1'b0, 1, 1'b0);
        @(negedge clk);
        do_reset(1);
        repeat (8) @(negedge clk);

        // Fresh operations after the abort.
        issue(0, 16'h1234, 16'h0FCD, 1'b0, 1'b0, 0, 1'b0);
        issue(1, 16'h0009, 16'h0003, 1'b1, 1'b1, 0, 1'b0);
        random_ops(0, 10);
        drain();
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
